// File: rtl/ppu_timing_if.sv
// Signal bundle between the PPU core and the dot/line timing block.
// The slave side is the timing block. The master side drives dot enables and
// pixel data, and observes the beam position, colour and vblank/NMI state.
interface ppu_timing_if;
   logic       ce;
   logic       pal;
   logic       rendering;
   logic [5:0] pixel_in;
   logic       grayscale;
   logic       nmi_enable;
   logic       read_status;
   logic [8:0] count_h;
   logic [8:0] count_v;
   logic [5:0] color;
   logic       vbl_flag;
   logic       nmi;
   logic       odd_frame;

   modport master (
      output ce, pal, rendering, pixel_in, grayscale, nmi_enable, read_status,
      input  count_h, count_v, color, vbl_flag, nmi, odd_frame
   );

   modport slave (
      input  ce, pal, rendering, pixel_in, grayscale, nmi_enable, read_status,
      output count_h, count_v, color, vbl_flag, nmi, odd_frame
   );
endinterface

// File: rtl/ppu_timing.sv
// PPU beam timing: dot/line counters with the NTSC odd-frame dot skip,
// a registered colour output, and the vblank flag / NMI generation.
// The pre-render line is a decoded line value (511), not a counter overflow.
module ppu_timing #(
   parameter int DOTS       = 341,
   parameter int LINES_NTSC = 262,
   parameter int LINES_PAL  = 312
) (
   input  logic         clk,
   input  logic         reset_n,
   ppu_timing_if.slave  bus
);
   localparam logic [8:0] PRE         = 9'd511;
   localparam logic [8:0] VBL_LINE    = 9'd241;
   localparam logic [8:0] H_LAST      = 9'(DOTS - 1);
   localparam logic [8:0] H_SKIP      = 9'(DOTS - 2);
   localparam logic [8:0] V_LAST_NTSC = 9'(LINES_NTSC - 2);
   localparam logic [8:0] V_LAST_PAL  = 9'(LINES_PAL - 2);

   logic [8:0] h_q, h_n, v_q, v_n, v_last;
   logic       pal_q, pal_n, odd_q, odd_n;
   logic       vbl_q, vbl_n, sup_q, sup_n, nmi_q;
   logic [5:0] color_q;
   logic       skip, set_evt, clr_evt;

   // Frame format is the one latched at the start of the frame, so a mid-frame
   // change of pal cannot shorten or stretch the frame in progress.
   assign v_last  = pal_q ? V_LAST_PAL : V_LAST_NTSC;
   assign skip    = (v_q == PRE) && (h_q == H_SKIP) && !pal_q && bus.rendering && odd_q;
   assign set_evt = bus.ce && (v_q == VBL_LINE) && (h_q == 9'd1);
   assign clr_evt = bus.ce && (v_q == PRE) && (h_q == 9'd1);

   // Next beam position, frame parity and latched frame format.
   always_comb begin
      h_n   = h_q;
      v_n   = v_q;
      odd_n = odd_q;
      pal_n = pal_q;
      if (bus.ce) begin
         if (h_q == H_LAST || skip) begin
            h_n = 9'd0;
            if (v_q == PRE) begin
               v_n   = 9'd0;
               odd_n = ~odd_q;
               pal_n = bus.pal;
            end else if (v_q == v_last) begin
               v_n = PRE;
            end else begin
               v_n = v_q + 9'd1;
            end
         end else begin
            h_n = h_q + 9'd1;
         end
      end
   end

   // Vblank flag and suppress latch. A status read wins over the set event;
   // when both coincide the frame's NMI is suppressed until pre-render.
   always_comb begin
      vbl_n = vbl_q;
      sup_n = sup_q;
      if (clr_evt) begin
         vbl_n = 1'b0;
         sup_n = 1'b0;
      end
      if (set_evt) begin
         if (bus.read_status) sup_n = 1'b1;
         else                 vbl_n = 1'b1;
      end
      if (bus.read_status) vbl_n = 1'b0;
   end

   // State registers; counters and colour move only on ce, flags every clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q     <= 9'd0;
         v_q     <= 9'd0;
         pal_q   <= 1'b0;
         odd_q   <= 1'b0;
         vbl_q   <= 1'b0;
         sup_q   <= 1'b0;
         nmi_q   <= 1'b0;
         color_q <= 6'd0;
      end else begin
         h_q   <= h_n;
         v_q   <= v_n;
         pal_q <= pal_n;
         odd_q <= odd_n;
         vbl_q <= vbl_n;
         sup_q <= sup_n;
         nmi_q <= vbl_n & bus.nmi_enable & ~sup_q;
         if (bus.ce)
            color_q <= bus.grayscale ? (bus.pixel_in & 6'h30) : bus.pixel_in;
      end
   end

   assign bus.count_h   = h_q;
   assign bus.count_v   = v_q;
   assign bus.color     = color_q;
   assign bus.vbl_flag  = vbl_q;
   assign bus.nmi       = nmi_q;
   assign bus.odd_frame = odd_q;
endmodule

// File: tb/tb_ppu_timing.sv
// Directed bench for ppu_timing. DOTS is shrunk to 10 so that several full
// frames fit in a short run. Line counts and the 241/511 event lines stay at
// their defaults. A bench-side dot index k tracks the beam position in the
// current frame.
module tb_ppu_timing;
   localparam int D     = 10;
   localparam int PRE_N = 261;   // frame-index row of the pre-render line, NTSC
   localparam int PRE_P = 311;   // same, PAL

   logic clk;
   logic reset_n;
   int   checks;
   int   passed;
   int   k;

   ppu_timing_if bus();

   ppu_timing #(.DOTS(D), .LINES_NTSC(262), .LINES_PAL(312)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n consecutive dots, ce held high for n clks
   task automatic adv(input int n);
      bus.ce = 1'b1;
      repeat (n) tick();
      bus.ce = 1'b0;
      k = k + n;
   endtask

   function automatic int idx(input int v, input int h, input int pre);
      return ((v == 511) ? pre : v) * D + h;
   endfunction

   task automatic go(input int v, input int h, input int pre);
      adv(idx(v, h, pre) - k);
   endtask

   task automatic test_reset();
      #12;
      checks++; if ({bus.count_v, bus.count_h} !== 18'd0) $display("FAIL rst_pos got %0d/%0d want 0/0", bus.count_v, bus.count_h); else passed++;
      checks++; if (bus.color !== 6'd0) $display("FAIL rst_color got %h want 00", bus.color); else passed++;
      checks++; if (bus.vbl_flag !== 1'b0) $display("FAIL rst_vbl got %b want 0", bus.vbl_flag); else passed++;
      checks++; if (bus.nmi !== 1'b0) $display("FAIL rst_nmi got %b want 0", bus.nmi); else passed++;
      checks++; if (bus.odd_frame !== 1'b0) $display("FAIL rst_odd got %b want 0", bus.odd_frame); else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      k = 0;
   endtask

   task automatic test_first_ce();
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd0, 9'd1}) $display("FAIL first_ce got %0d/%0d want 0/1", bus.count_v, bus.count_h); else passed++;
      repeat (3) tick();
      checks++; if ({bus.count_v, bus.count_h} !== {9'd0, 9'd1}) $display("FAIL ce_hold got %0d/%0d want 0/1", bus.count_v, bus.count_h); else passed++;
   endtask

   task automatic test_ntsc_frames();
      bus.rendering = 1'b0;
      go(260, 9, PRE_N);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd260, 9'd9}) $display("FAIL ntsc_last got %0d/%0d want 260/9", bus.count_v, bus.count_h); else passed++;
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd0}) $display("FAIL ntsc_pre got %0d/%0d want 511/0", bus.count_v, bus.count_h); else passed++;
      go(511, 9, PRE_N);
      checks++; if (bus.odd_frame !== 1'b0) $display("FAIL ntsc_odd0 got %b want 0", bus.odd_frame); else passed++;
      adv(1); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b1}) $display("FAIL ntsc_wrap1 got %0d/%0d odd=%b want 0/0 odd=1", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
      adv(262 * D); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b0}) $display("FAIL ntsc_wrap2 got %0d/%0d odd=%b want 0/0 odd=0", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
   endtask

   task automatic test_odd_skip();
      bus.rendering = 1'b0;
      adv(262 * D); k = 0;
      checks++; if (bus.odd_frame !== 1'b1) $display("FAIL skip_pre_odd got %b want 1", bus.odd_frame); else passed++;
      bus.rendering = 1'b1;
      go(511, 8, PRE_N);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd8}) $display("FAIL skip_at got %0d/%0d want 511/8", bus.count_v, bus.count_h); else passed++;
      adv(1); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b0}) $display("FAIL skip_jump got %0d/%0d odd=%b want 0/0 odd=0", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
      go(511, 8, PRE_N);
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd9}) $display("FAIL even_noskip got %0d/%0d want 511/9", bus.count_v, bus.count_h); else passed++;
      adv(1); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b1}) $display("FAIL even_wrap got %0d/%0d odd=%b want 0/0 odd=1", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
      bus.rendering = 1'b0;
      go(511, 8, PRE_N);
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd9}) $display("FAIL norender_noskip got %0d/%0d want 511/9", bus.count_v, bus.count_h); else passed++;
      adv(1); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b0}) $display("FAIL norender_wrap got %0d/%0d odd=%b want 0/0 odd=0", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
   endtask

   task automatic test_pal();
      bus.rendering = 1'b1;
      go(10, 0, PRE_N);
      bus.pal = 1'b1;
      go(260, 9, PRE_N);
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd0}) $display("FAIL pal_late got %0d/%0d want 511/0", bus.count_v, bus.count_h); else passed++;
      go(511, 9, PRE_N);
      adv(1); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b1}) $display("FAIL pal_enter got %0d/%0d odd=%b want 0/0 odd=1", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
      go(5, 0, PRE_P);
      bus.pal = 1'b0;
      go(260, 9, PRE_P);
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd261, 9'd0}) $display("FAIL pal_line261 got %0d/%0d want 261/0", bus.count_v, bus.count_h); else passed++;
      go(310, 9, PRE_P);
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd0}) $display("FAIL pal_pre got %0d/%0d want 511/0", bus.count_v, bus.count_h); else passed++;
      go(511, 8, PRE_P);
      adv(1);
      checks++; if ({bus.count_v, bus.count_h} !== {9'd511, 9'd9}) $display("FAIL pal_noskip got %0d/%0d want 511/9", bus.count_v, bus.count_h); else passed++;
      adv(1); k = 0;
      checks++; if ({bus.count_v, bus.count_h, bus.odd_frame} !== {9'd0, 9'd0, 1'b0}) $display("FAIL pal_wrap got %0d/%0d odd=%b want 0/0 odd=0", bus.count_v, bus.count_h, bus.odd_frame); else passed++;
   endtask

   task automatic test_vbl_nmi();
      bus.rendering  = 1'b0;
      bus.nmi_enable = 1'b1;
      go(241, 1, PRE_N);
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b00) $display("FAIL vbl_before got vbl=%b nmi=%b want 0 0", bus.vbl_flag, bus.nmi); else passed++;
      adv(1);
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b11) $display("FAIL vbl_set got vbl=%b nmi=%b want 1 1", bus.vbl_flag, bus.nmi); else passed++;
      go(250, 0, PRE_N);
      bus.read_status = 1'b1;
      tick();
      bus.read_status = 1'b0;
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b00) $display("FAIL vbl_read got vbl=%b nmi=%b want 0 0", bus.vbl_flag, bus.nmi); else passed++;
      go(511, 1, PRE_N);
      adv(1);
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b00) $display("FAIL vbl_preclr got vbl=%b nmi=%b want 0 0", bus.vbl_flag, bus.nmi); else passed++;
      go(511, 9, PRE_N);
      adv(1); k = 0;
   endtask

   task automatic test_nmi_enable_edge();
      bus.nmi_enable = 1'b0;
      go(241, 1, PRE_N);
      adv(1);
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b10) $display("FAIL en0_set got vbl=%b nmi=%b want 1 0", bus.vbl_flag, bus.nmi); else passed++;
      bus.nmi_enable = 1'b1;
      tick();
      checks++; if (bus.nmi !== 1'b1) $display("FAIL en_rise got nmi=%b want 1", bus.nmi); else passed++;
      bus.nmi_enable = 1'b0;
      tick();
      checks++; if (bus.nmi !== 1'b0) $display("FAIL en_fall got nmi=%b want 0", bus.nmi); else passed++;
      go(511, 1, PRE_N);
      adv(1);
      checks++; if (bus.vbl_flag !== 1'b0) $display("FAIL en_preclr got vbl=%b want 0", bus.vbl_flag); else passed++;
      go(511, 9, PRE_N);
      adv(1); k = 0;
   endtask

   task automatic test_race();
      bus.nmi_enable = 1'b1;
      go(241, 1, PRE_N);
      bus.ce          = 1'b1;
      bus.read_status = 1'b1;
      tick();
      bus.ce          = 1'b0;
      bus.read_status = 1'b0;
      k = k + 1;
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b00) $display("FAIL race_set got vbl=%b nmi=%b want 0 0", bus.vbl_flag, bus.nmi); else passed++;
      bus.nmi_enable = 1'b0;
      tick();
      bus.nmi_enable = 1'b1;
      tick();
      go(260, 9, PRE_N);
      checks++; if ({bus.vbl_flag, bus.nmi} !== 2'b00) $display("FAIL race_hold got vbl=%b nmi=%b want 0 0", bus.vbl_flag, bus.nmi); else passed++;
      go(511, 9, PRE_N);
      adv(1); k = 0;
   endtask

   task automatic test_color();
      bus.grayscale = 1'b1;
      bus.pixel_in  = 6'h2A;
      adv(1);
      checks++; if (bus.color !== 6'h20) $display("FAIL color_gray got %h want 20", bus.color); else passed++;
      bus.grayscale = 1'b0;
      bus.pixel_in  = 6'h15;
      adv(1);
      checks++; if (bus.color !== 6'h15) $display("FAIL color_pass got %h want 15", bus.color); else passed++;
      bus.pixel_in  = 6'h3F;
      tick();
      checks++; if (bus.color !== 6'h15) $display("FAIL color_hold got %h want 15", bus.color); else passed++;
   endtask

   task automatic test_reset_midframe();
      bus.nmi_enable = 1'b1;
      go(250, 5, PRE_N);
      checks++; if ({bus.vbl_flag, bus.nmi, bus.odd_frame} !== 3'b111) $display("FAIL mid_pre got vbl=%b nmi=%b odd=%b want 1 1 1", bus.vbl_flag, bus.nmi, bus.odd_frame); else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if ({bus.count_v, bus.count_h} !== 18'd0) $display("FAIL mid_pos got %0d/%0d want 0/0", bus.count_v, bus.count_h); else passed++;
      checks++; if ({bus.color, bus.vbl_flag, bus.nmi, bus.odd_frame} !== 9'd0) $display("FAIL mid_flags got color=%h vbl=%b nmi=%b odd=%b want all 0", bus.color, bus.vbl_flag, bus.nmi, bus.odd_frame); else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      k = 0;
      adv(1);
      checks++; if ({bus.count_v, bus.count_h, bus.vbl_flag, bus.nmi} !== {9'd0, 9'd1, 2'b00}) $display("FAIL mid_restart got %0d/%0d vbl=%b nmi=%b want 0/1 0 0", bus.count_v, bus.count_h, bus.vbl_flag, bus.nmi); else passed++;
   endtask

   initial begin
      checks          = 0;
      passed          = 0;
      k               = 0;
      reset_n         = 1'b0;
      bus.ce          = 1'b0;
      bus.pal         = 1'b0;
      bus.rendering   = 1'b0;
      bus.pixel_in    = 6'd0;
      bus.grayscale   = 1'b0;
      bus.nmi_enable  = 1'b0;
      bus.read_status = 1'b0;
      test_reset();
      test_first_ce();
      test_ntsc_frames();
      test_odd_skip();
      test_pal();
      test_vbl_nmi();
      test_nmi_enable_edge();
      test_race();
      test_color();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
